// File: rtl/bellek_hakemi_pkg.sv
// bellek_hakemi_pkg: winner codes and default widths shared by the arbiter and pipeline stages
package bellek_hakemi_pkg;
  localparam int VARSAYILAN_ADRES_BIT = 32;
  localparam int VARSAYILAN_VERI_BIT = 32;
  typedef enum logic [1:0] {
    KAZANAN_YOK   = 2'd0,
    KAZANAN_GETIR = 2'd1,
    KAZANAN_VERI  = 2'd2
  } kazanan_t;
endpackage

// File: rtl/bellek_hakemi_aclik_sayaci.sv
// aclik_sayaci: saturating count of denied fetch cycles; oncelik hands fetch the priority
// Ports: clk, rst (sync active-low), bekliyor (fetch denied), temizle (clear), oncelik (limit reached)
module aclik_sayaci #(
  parameter int SINIR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bekliyor,
  input  logic temizle,
  output logic oncelik
);
  localparam int W = $clog2(SINIR + 1);
  logic [W-1:0] sayac;
  always_ff @(posedge clk)
    if (!rst || temizle) sayac <= '0;
    else if (bekliyor && sayac != W'(SINIR)) sayac <= sayac + 1'b1;
  assign oncelik = sayac >= W'(SINIR);
endmodule

// File: rtl/bellek_hakemi.sv
// bellek_hakemi: single-port memory arbiter between fetch reads and data loads/stores
// Ports: getir_* fetch request/response, veri_* data request/response, bellek_* memory pins;
// clk rising edge, rst synchronous active-low. Responses arrive one cycle after the grant.
module bellek_hakemi
  import bellek_hakemi_pkg::*;
#(
  parameter int ADRES_BIT    = VARSAYILAN_ADRES_BIT,
  parameter int VERI_BIT     = VARSAYILAN_VERI_BIT,
  parameter int ACLIK_SINIRI = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 getir_istek,
  input  logic [ADRES_BIT-1:0] getir_adres,
  output logic                 getir_hazir,
  output logic                 getir_yanit_gecerli,
  output logic [VERI_BIT-1:0]  getir_veri,
  input  logic                 veri_istek,
  input  logic                 veri_yaz,
  input  logic [ADRES_BIT-1:0] veri_adres,
  input  logic [VERI_BIT-1:0]  veri_yaz_veri,
  output logic                 veri_hazir,
  output logic                 veri_yanit_gecerli,
  output logic [VERI_BIT-1:0]  veri_oku_veri,
  output logic [ADRES_BIT-1:0] bellek_adres,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz_gecerli,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri
);
  kazanan_t kazanan_r, kazanan_n;
  logic oncelik;
  aclik_sayaci #(.SINIR(ACLIK_SINIRI)) u_aclik (
    .clk     (clk),
    .rst     (rst),
    .bekliyor(getir_istek && !getir_hazir),
    .temizle (!getir_istek || getir_hazir),
    .oncelik (oncelik)
  );
  // Data wins ties unless fetch has starved long enough; valids are gated so a
  // reset in the response cycle drops the pending response.
  always_comb begin
    veri_hazir = rst && veri_istek && !(getir_istek && oncelik);
    getir_hazir = rst && getir_istek && !veri_hazir;
    kazanan_n = getir_hazir ? KAZANAN_GETIR : veri_hazir ? KAZANAN_VERI : KAZANAN_YOK;
    bellek_adres = veri_hazir ? veri_adres : getir_adres;
    bellek_yaz_veri = veri_yaz_veri;
    bellek_yaz_gecerli = veri_hazir && veri_yaz;
    getir_yanit_gecerli = rst && kazanan_r == KAZANAN_GETIR;
    veri_yanit_gecerli = rst && kazanan_r == KAZANAN_VERI;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      kazanan_r <= KAZANAN_YOK;
      getir_veri <= '0;
      veri_oku_veri <= '0;
    end else begin
      kazanan_r <= kazanan_n;
      if (getir_hazir) getir_veri <= bellek_oku_veri;
      if (veri_hazir) veri_oku_veri <= veri_yaz ? '0 : bellek_oku_veri;
    end
endmodule

// File: tb/tb_bellek_hakemi.sv
// tb_bellek_hakemi: directed stimulus with a queue scoreboard checked by a separate monitor
module tb_bellek_hakemi;
  logic clk = 0, rst = 0;
  logic getir_istek = 0, veri_istek = 0, veri_yaz = 0;
  logic [31:0] getir_adres = 0, veri_adres = 0, veri_yaz_veri = 0;
  logic getir_hazir, getir_yanit_gecerli, veri_hazir, veri_yanit_gecerli, bellek_yaz_gecerli;
  logic [31:0] getir_veri, veri_oku_veri, bellek_adres, bellek_yaz_veri, bellek_oku_veri;
  logic [31:0] mem [0:1023];
  typedef struct {logic [31:0] v; int c;} bek_t;
  bek_t gq[$], vq[$];
  int total = 0, bad = 0, cyc = 0, yaz_sayisi = 0, w0;

  bellek_hakemi dut (
    .clk(clk), .rst(rst),
    .getir_istek(getir_istek), .getir_adres(getir_adres), .getir_hazir(getir_hazir),
    .getir_yanit_gecerli(getir_yanit_gecerli), .getir_veri(getir_veri),
    .veri_istek(veri_istek), .veri_yaz(veri_yaz), .veri_adres(veri_adres),
    .veri_yaz_veri(veri_yaz_veri), .veri_hazir(veri_hazir),
    .veri_yanit_gecerli(veri_yanit_gecerli), .veri_oku_veri(veri_oku_veri),
    .bellek_adres(bellek_adres), .bellek_yaz_veri(bellek_yaz_veri),
    .bellek_yaz_gecerli(bellek_yaz_gecerli), .bellek_oku_veri(bellek_oku_veri)
  );

  always #5 clk = ~clk;
  assign bellek_oku_veri = mem[bellek_adres[11:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bellek_yaz_gecerli) begin
      mem[bellek_adres[11:2]] <= bellek_yaz_veri;
      yaz_sayisi <= yaz_sayisi + 1;
    end
  end

  task automatic chk(string ad, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", ad, a, e);
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    bek_t b;
    if (getir_yanit_gecerli) begin
      total++;
      if (gq.size() == 0) begin
        bad++;
        $display("FAIL getir_unexpected: got %h at cycle %0d want no response", getir_veri, cyc);
      end else begin
        b = gq.pop_front();
        if (getir_veri !== b.v || cyc != b.c) begin
          bad++;
          $display("FAIL getir_resp: got %h at cycle %0d want %h at cycle %0d", getir_veri, cyc, b.v, b.c);
        end
      end
    end else if (gq.size() > 0 && gq[0].c < cyc) begin
      total++;
      bad++;
      b = gq.pop_front();
      $display("FAIL getir_missing: got none want %h at cycle %0d", b.v, b.c);
    end
    if (veri_yanit_gecerli) begin
      total++;
      if (vq.size() == 0) begin
        bad++;
        $display("FAIL veri_unexpected: got %h at cycle %0d want no response", veri_oku_veri, cyc);
      end else begin
        b = vq.pop_front();
        if (veri_oku_veri !== b.v || cyc != b.c) begin
          bad++;
          $display("FAIL veri_resp: got %h at cycle %0d want %h at cycle %0d", veri_oku_veri, cyc, b.v, b.c);
        end
      end
    end else if (vq.size() > 0 && vq[0].c < cyc) begin
      total++;
      bad++;
      b = vq.pop_front();
      $display("FAIL veri_missing: got none want %h at cycle %0d", b.v, b.c);
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
    mem[256] = 32'hdead_bee0;
    // reset with both ports requesting a store: nothing may be granted
    getir_istek = 1; getir_adres = 32'h8000_0000;
    veri_istek = 1; veri_yaz = 1; veri_adres = 32'h8000_0408; veri_yaz_veri = 32'h1234_5678;
    @(negedge clk);
    chk("rst_getir_hazir", getir_hazir, 0);
    chk("rst_veri_hazir", veri_hazir, 0);
    chk("rst_yaz", bellek_yaz_gecerli, 0);
    @(negedge clk);
    chk("rst_getir_gecerli", getir_yanit_gecerli, 0);
    chk("rst_veri_gecerli", veri_yanit_gecerli, 0);
    chk("rst_getir_veri", getir_veri, 0);
    chk("rst_veri_oku", veri_oku_veri, 0);
    adim();
    getir_istek = 0; veri_istek = 0; veri_yaz = 0; rst = 1;
    // fetch alone
    adim();
    getir_istek = 1; getir_adres = 32'h8000_0000;
    @(negedge clk);
    chk("t1_getir_hazir", getir_hazir, 1);
    chk("t1_adres", bellek_adres, 32'h8000_0000);
    gq.push_back('{32'h0050_0093, cyc + 1});
    // load and fetch together: data first, fetch next cycle
    adim();
    getir_adres = 32'h8000_0004;
    veri_istek = 1; veri_yaz = 0; veri_adres = 32'h8000_0400;
    @(negedge clk);
    chk("t2_veri_hazir", veri_hazir, 1);
    chk("t2_getir_hazir", getir_hazir, 0);
    chk("t2_adres", bellek_adres, 32'h8000_0400);
    vq.push_back('{32'hdead_bee0, cyc + 1});
    gq.push_back('{32'h00a0_0113, cyc + 2});
    adim();
    veri_istek = 0;
    @(negedge clk);
    chk("t2_getir_hazir2", getir_hazir, 1);
    // store then read-after-write
    adim();
    getir_istek = 0;
    veri_istek = 1; veri_yaz = 1; veri_adres = 32'h8000_0404; veri_yaz_veri = 32'h5555_5555;
    w0 = yaz_sayisi;
    @(negedge clk);
    chk("t3_veri_hazir", veri_hazir, 1);
    chk("t3_yaz", bellek_yaz_gecerli, 1);
    chk("t3_yaz_veri", bellek_yaz_veri, 32'h5555_5555);
    vq.push_back('{32'h0, cyc + 1});
    adim();
    veri_yaz = 0;
    @(negedge clk);
    chk("t3_yuk_hazir", veri_hazir, 1);
    chk("t3_yuk_yaz", bellek_yaz_gecerli, 0);
    vq.push_back('{32'h5555_5555, cyc + 1});
    adim();
    veri_istek = 0;
    @(negedge clk);
    chk("t3_yaz_sayisi", yaz_sayisi - w0, 1);
    // both ports continuously: VVVVG repeating
    adim();
    getir_istek = 1; getir_adres = 32'h8000_0000;
    veri_istek = 1; veri_yaz = 0; veri_adres = 32'h8000_0400;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("t4_getir_%0d", i), getir_hazir, (i % 5 == 4) ? 1 : 0);
      chk($sformatf("t4_veri_%0d", i), veri_hazir, (i % 5 == 4) ? 0 : 1);
      if (i % 5 == 4) gq.push_back('{32'h0050_0093, cyc + 1});
      else vq.push_back('{32'hdead_bee0, cyc + 1});
      if (i < 19) @(posedge clk);
    end
    adim();
    getir_istek = 0; veri_istek = 0;
    // reset right after a load grant drops the response
    adim();
    veri_istek = 1; veri_yaz = 0; veri_adres = 32'h8000_0400;
    @(negedge clk);
    chk("t5_veri_hazir", veri_hazir, 1);
    adim();
    rst = 0; getir_istek = 1; veri_yaz = 1; veri_adres = 32'h8000_0408; veri_yaz_veri = 32'h1234_5678;
    @(negedge clk);
    chk("t5_veri_gecerli", veri_yanit_gecerli, 0);
    chk("t5_hazir", {getir_hazir, veri_hazir}, 0);
    chk("t5_yaz", bellek_yaz_gecerli, 0);
    adim();
    @(negedge clk);
    chk("t5_getir_veri", getir_veri, 0);
    chk("t5_veri_oku", veri_oku_veri, 0);
    chk("t5_gecerli", {getir_yanit_gecerli, veri_yanit_gecerli}, 0);
    chk("t5_yaz2", bellek_yaz_gecerli, 0);
    adim();
    getir_istek = 0; veri_istek = 0; veri_yaz = 0; rst = 1;
    // data request withdrawn while fetch holds priority
    adim();
    getir_istek = 1; getir_adres = 32'h8000_0004;
    veri_istek = 1; veri_yaz = 0; veri_adres = 32'h8000_0400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_veri_%0d", i), veri_hazir, 1);
      vq.push_back('{32'hdead_bee0, cyc + 1});
      adim();
    end
    veri_yaz = 1; veri_adres = 32'h8000_0408; veri_yaz_veri = 32'hcafe_f00d;
    w0 = yaz_sayisi;
    @(negedge clk);
    chk("t6_veri_hazir", veri_hazir, 0);
    chk("t6_getir_hazir", getir_hazir, 1);
    chk("t6_yaz", bellek_yaz_gecerli, 0);
    gq.push_back('{32'h00a0_0113, cyc + 1});
    adim();
    getir_istek = 0; veri_istek = 0; veri_yaz = 0;
    @(negedge clk);
    chk("t6_veri_hazir2", veri_hazir, 0);
    adim();
    adim();
    @(negedge clk);
    chk("t6_yaz_sayisi", yaz_sayisi - w0, 0);
    chk("t6_mem", mem[258], 0);
    chk("gq_bos", gq.size(), 0);
    chk("vq_bos", vq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bellek_hakemi.md
# bellek_hakemi

Arbiter sharing the single-port main memory (`HelperMemory`, combinational read, write on `clk` edge) between the fetch stage (instruction reads) and the memory stage (data loads and stores). Sits between `Processpr` pipeline stages and the memory's `adres`/`oku_veri`/`yaz_veri`/`yaz_gecerli` pins. Grants at most one access per cycle, with data-port priority and a starvation guard for fetch. Each response returns one cycle after its grant.

## Interface
- `ADRES_BIT`, 32, address width
- `VERI_BIT`, 32, data width
- `ACLIK_SINIRI`, 4, consecutive denied fetch cycles before fetch gets priority (≥1)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `getir_istek`  in  1  fetch read request
- `getir_adres`  in  ADRES_BIT  fetch address
- `getir_hazir`  out  1  fetch request accepted this cycle
- `getir_yanit_gecerli`  out  1  `getir_veri` valid
- `getir_veri`  out  VERI_BIT  instruction word
- `veri_istek`  in  1  data request
- `veri_yaz`  in  1  1 = store, 0 = load
- `veri_adres`  in  ADRES_BIT  data address
- `veri_yaz_veri`  in  VERI_BIT  store data
- `veri_hazir`  out  1  data request accepted this cycle
- `veri_yanit_gecerli`  out  1  load data valid / store acknowledged
- `veri_oku_veri`  out  VERI_BIT  load data (0 for stores)
- `bellek_adres`  out  ADRES_BIT  memory address
- `bellek_yaz_veri`  out  VERI_BIT  memory write data
- `bellek_yaz_gecerli`  out  1  memory write enable
- `bellek_oku_veri`  in  VERI_BIT  memory read data (combinational)

## Operation
- Grant is combinational from current requests plus registered starvation state. Handshake: accepted when `*_istek && *_hazir`.
- Priority: data port wins when both request, unless `aclik_sayaci >= ACLIK_SINIRI`; then fetch wins.
- `aclik_sayaci`: +1 each cycle `getir_istek` is high and not granted, saturating at `ACLIK_SINIRI`. Cleared on a fetch grant or when `getir_istek` is low.
- Memory mux: winner's address drives `bellek_adres`. `bellek_yaz_gecerli` = data grant && `veri_yaz`. `bellek_yaz_veri` = `veri_yaz_veri`. With no grant: `bellek_adres` = `getir_adres`, write enable 0.
- On grant, `bellek_oku_veri` is captured into the winner's response register. `kazanan_r` ∈ {YOK, GETIR, VERI} is registered for routing.
- Store: `veri_yanit_gecerli` pulses next cycle with `veri_oku_veri` = 0. The memory write occurs on the grant edge.
- Requesters hold `istek`, address, and write data stable until `hazir`. Dropping `istek` before `hazir` is allowed; the request is then discarded.
- Response data registers hold their value until the next response on that port.

## Timing
- Reset (`rst`=0 at edge): `kazanan_r`=YOK, `aclik_sayaci`=0, both `yanit_gecerli`=0, `getir_veri`=`veri_oku_veri`=0.
- While `rst`=0: both `hazir`=0 and `bellek_yaz_gecerli`=0, combinationally.
- Reset asserted in the cycle after a grant: the pending response is dropped, no `yanit_gecerli`.
- Latency: grant in cycle N → `yanit_gecerli` high for exactly cycle N+1.
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses.
- Both ports requesting continuously with default limit: data granted 4 cycles, fetch granted once, then repeat. Fetch waits at most `ACLIK_SINIRI` cycles.
- Read-after-write to the same address in consecutive grants returns the new data.

## Structure
- Shared package/header: `KAZANAN_YOK=2'd0`, `KAZANAN_GETIR=2'd1`, `KAZANAN_VERI=2'd2`, and default `ADRES_BIT`/`VERI_BIT`. Reused by the fetch and memory stages.
- One sub-module, `aclik_sayaci`: saturating counter with inputs `bekliyor` and `temizle`, parameter `SINIR`, output `oncelik`.

## Test plan
- Reset, then fetch only, `getir_adres`=0x8000_0000 with memory holding 0x00500093 → `getir_hazir`=1 same cycle; next cycle `getir_yanit_gecerli`=1, `getir_veri`=0x00500093.
- Load at 0x8000_0400 (0xdeadbee0) while fetch requests 0x8000_0004 → data granted first; fetch granted next cycle; responses 0xdeadbee0 then 0x00a00113 on consecutive cycles.
- Store 0x55555555 to 0x8000_0404, then load from 0x8000_0404 in the next cycle → `bellek_yaz_gecerli` pulses once; store ack with `veri_oku_veri`=0; load returns 0x55555555.
- Both ports requesting continuously for 20 cycles → grant pattern VVVVG repeating; no fetch wait exceeds 4 cycles; `aclik_sayaci` never exceeds 4.
- `rst`=0 asserted the cycle after a load grant → no `veri_yanit_gecerli`; all outputs at reset values; `bellek_yaz_gecerli`=0 throughout reset.
- `veri_istek` dropped before grant (fetch holding priority) → no memory write, no data response.
